// File: rtl/sfifo_sdpramb_ctrl.sv
// sfifo_sdpramb_ctrl: single-clock FIFO controller around a simple-dual-port block RAM
`ifndef RAM_OUT_REG
`define RAM_OUT_REG 0
`endif

module sdpramb_sclk #(
  parameter int WRITE_WIDTH    = 8,
  parameter int WRITE_DEPTHBIT = 10,
  parameter int READ_WIDTH     = 8,
  parameter int READ_DEPTHBIT  = 10,
  parameter int RAM_OUT_REG    = 0,
  parameter int R_W_TYPE_MIX   = 0
) (
  input  logic                      clock,
  input  logic                      enable,
  input  logic                      wren,
  input  logic [WRITE_DEPTHBIT-1:0] wraddress,
  input  logic [WRITE_WIDTH-1:0]    data,
  input  logic [READ_DEPTHBIT-1:0]  rdaddress,
  output logic [READ_WIDTH-1:0]     q
);
  logic [WRITE_WIDTH-1:0] mem [2**WRITE_DEPTHBIT];
  logic [READ_WIDTH-1:0] q_r, q_o;
  // synchronous write, registered read with optional output register; collisions return new or old data
  always_ff @(posedge clock)
    if (enable) begin
      if (wren) mem[wraddress] <= data;
      q_r <= (R_W_TYPE_MIX != 0 && wren && wraddress == rdaddress) ? data : mem[rdaddress];
      q_o <= q_r;
    end
  assign q = (RAM_OUT_REG != 0) ? q_o : q_r;
endmodule

module sfifo_sdpramb_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTHBIT    = 10,
  parameter int RAM_OUT_REG = `RAM_OUT_REG,
  parameter int AFULL_TH    = 2**DEPTHBIT-4,
  parameter int AEMPTY_TH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  sclr,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvld,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [DEPTHBIT:0]     count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [DEPTHBIT:0] depth = {1'b1, {DEPTHBIT{1'b0}}};
  localparam logic [DEPTHBIT:0] afull_th = (DEPTHBIT+1)'(AFULL_TH);
  localparam logic [DEPTHBIT:0] aempty_th = (DEPTHBIT+1)'(AEMPTY_TH);
  logic [DEPTHBIT:0] wptr, rptr, cnt_nx;
  logic [1:0] vpipe;
  logic wr_acc, rd_acc;
  assign wr_acc = wen & ~full & ~sclr;
  assign rd_acc = ren & ~empty & ~sclr;
  assign cnt_nx = count + (DEPTHBIT+1)'(wr_acc) - (DEPTHBIT+1)'(rd_acc);
  assign rvld = (RAM_OUT_REG != 0) ? vpipe[1] : vpipe[0];
  // pointers, occupancy, flags from next count, error pulses and read-valid pipeline
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      vpipe     <= '0;
    end else begin
      wptr      <= sclr ? '0 : wptr + (DEPTHBIT+1)'(wr_acc);
      rptr      <= sclr ? '0 : rptr + (DEPTHBIT+1)'(rd_acc);
      count     <= sclr ? '0 : cnt_nx;
      full      <= ~sclr & (cnt_nx == depth);
      empty     <= sclr | (cnt_nx == '0);
      afull     <= ~sclr & (cnt_nx >= afull_th);
      aempty    <= sclr | (cnt_nx <= aempty_th);
      overflow  <= wen & full & ~sclr;
      underflow <= ren & empty & ~sclr;
      vpipe     <= sclr ? '0 : {vpipe[0], rd_acc};
    end
  sdpramb_sclk #(
    .WRITE_WIDTH(DATA_WIDTH),
    .WRITE_DEPTHBIT(DEPTHBIT),
    .READ_WIDTH(DATA_WIDTH),
    .READ_DEPTHBIT(DEPTHBIT),
    .RAM_OUT_REG(RAM_OUT_REG)
  ) u_ram (
    .clock(clock),
    .enable(1'b1),
    .wren(wr_acc),
    .wraddress(wptr[DEPTHBIT-1:0]),
    .data(wdata),
    .rdaddress(rptr[DEPTHBIT-1:0]),
    .q(rdata)
  );
endmodule

// File: tb/tb_sfifo_sdpramb_ctrl.sv
// tb_sfifo_sdpramb_ctrl: directed bench driving unregistered- and registered-output FIFOs in lockstep
module tb_sfifo_sdpramb_ctrl;
  logic clk = 1'b0, rst_n, sclr, wen, ren;
  logic [7:0] wdata, rdata0, rdata1;
  logic rvld0, full0, empty0, afull0, aempty0, overflow0, underflow0;
  logic rvld1, full1, empty1, afull1, aempty1, overflow1, underflow1;
  logic [4:0] count0, count1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sfifo_sdpramb_ctrl #(.DATA_WIDTH(8), .DEPTHBIT(4), .RAM_OUT_REG(0), .AFULL_TH(12), .AEMPTY_TH(4)) u0 (
    .clock(clk), .rst_n(rst_n), .sclr(sclr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata0), .rvld(rvld0), .full(full0), .empty(empty0), .afull(afull0), .aempty(aempty0),
    .count(count0), .overflow(overflow0), .underflow(underflow0));

  sfifo_sdpramb_ctrl #(.DATA_WIDTH(8), .DEPTHBIT(4), .RAM_OUT_REG(1), .AFULL_TH(12), .AEMPTY_TH(4)) u1 (
    .clock(clk), .rst_n(rst_n), .sclr(sclr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata1), .rvld(rvld1), .full(full1), .empty(empty1), .afull(afull1), .aempty(aempty1),
    .count(count1), .overflow(overflow1), .underflow(underflow1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; sclr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_count0", 32'(count0), 0);
    chk("rst_count1", 32'(count1), 0);
    chk("rst_empty0", 32'(empty0), 1);
    chk("rst_aempty0", 32'(aempty0), 1);
    chk("rst_full0", 32'(full0), 0);
    chk("rst_afull0", 32'(afull0), 0);
    chk("rst_rvld0", 32'(rvld0), 0);
    chk("rst_rvld1", 32'(rvld1), 0);
    chk("rst_ovf0", 32'(overflow0), 0);
    chk("rst_udf0", 32'(underflow0), 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 16; k++) begin
      wen = 1'b1; wdata = 8'(k);
      tick;
      chk("fill_count", 32'(count0), 32'(k + 1));
      chk("fill_afull", 32'(afull0), 32'(k >= 11));
      chk("fill_full", 32'(full0), 32'(k == 15));
      chk("fill_aempty", 32'(aempty0), 32'(k <= 3));
      chk("fill_empty", 32'(empty0), 0);
    end
    wdata = 8'hEE;
    tick;
    chk("ovf_pulse", 32'(overflow0), 1);
    chk("ovf_count", 32'(count0), 16);
    chk("ovf_full", 32'(full1), 1);
    wen = 1'b0;
    tick;
    chk("ovf_clear", 32'(overflow0), 0);
    chk("ovf_count2", 32'(count1), 16);
    for (int k = 0; k < 16; k++) begin
      ren = 1'b1;
      tick;
      chk("drain_rvld0", 32'(rvld0), 1);
      chk("drain_rdata0", 32'(rdata0), 32'(k));
      chk("drain_rvld1", 32'(rvld1), 32'(k > 0));
      if (k > 0) chk("drain_rdata1", 32'(rdata1), 32'(k - 1));
      chk("drain_count", 32'(count0), 32'(15 - k));
    end
    chk("drain_empty", 32'(empty0), 1);
    tick;
    chk("udf_pulse", 32'(underflow0), 1);
    chk("udf_rvld0", 32'(rvld0), 0);
    chk("udf_rvld1", 32'(rvld1), 1);
    chk("udf_rdata1", 32'(rdata1), 32'h0F);
    chk("udf_count", 32'(count0), 0);
    ren = 1'b0;
    tick;
    chk("udf_clear", 32'(underflow0), 0);
    chk("udf_rvld1_end", 32'(rvld1), 0);
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wdata = 8'(8'h20 + i);
      tick;
    end
    chk("wrap_pre_count", 32'(count0), 8);
    for (int i = 0; i < 40; i++) begin
      wen = 1'b1; ren = 1'b1; wdata = 8'(8'h28 + i);
      tick;
      chk("wrap_count", 32'(count0), 8);
      chk("wrap_rvld0", 32'(rvld0), 1);
      chk("wrap_rdata0", 32'(rdata0), 32'(8'h20 + i));
      if (i > 0) chk("wrap_rdata1", 32'(rdata1), 32'(8'h20 + i - 1));
    end
    wen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ren = 1'b1;
      tick;
      chk("wrap_tail0", 32'(rdata0), 32'(8'h48 + j));
      chk("wrap_tail_count", 32'(count0), 32'(7 - j));
    end
    ren = 1'b0;
    tick;
    chk("wrap_tail1_vld", 32'(rvld1), 1);
    chk("wrap_tail1", 32'(rdata1), 32'h4F);
    chk("wrap_empty", 32'(empty0), 1);
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = 8'(8'h30 + i);
      tick;
    end
    chk("bf_full", 32'(full0), 1);
    ren = 1'b1; wdata = 8'hFF;
    tick;
    chk("bf_ovf", 32'(overflow0), 1);
    chk("bf_count", 32'(count0), 15);
    chk("bf_full_clr", 32'(full0), 0);
    chk("bf_rvld0", 32'(rvld0), 1);
    chk("bf_rdata0", 32'(rdata0), 32'h30);
    wen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("bf_drain0", 32'(rdata0), 32'(8'h31 + i));
    end
    chk("bf_empty", 32'(empty0), 1);
    wen = 1'b1; wdata = 8'h77;
    tick;
    chk("be_udf", 32'(underflow0), 1);
    chk("be_count", 32'(count0), 1);
    chk("be_empty", 32'(empty0), 0);
    chk("be_rvld0", 32'(rvld0), 0);
    chk("be_rvld1", 32'(rvld1), 1);
    chk("be_rdata1", 32'(rdata1), 32'h3F);
    wen = 1'b0;
    tick;
    chk("be_rd_vld0", 32'(rvld0), 1);
    chk("be_rd_data0", 32'(rdata0), 32'h77);
    chk("be_udf_clr", 32'(underflow0), 0);
    ren = 1'b0;
    tick;
    chk("be_rd_vld1", 32'(rvld1), 1);
    chk("be_rd_data1", 32'(rdata1), 32'h77);
    chk("be_rvld0_end", 32'(rvld0), 0);
    for (int i = 0; i < 12; i++) begin
      wen = 1'b1; wdata = 8'(8'h50 + i);
      tick;
    end
    chk("fl_afull", 32'(afull0), 1);
    wen = 1'b0; ren = 1'b1;
    tick;
    tick;
    chk("fl_pre_count", 32'(count0), 10);
    chk("fl_pre_rvld1", 32'(rvld1), 1);
    sclr = 1'b1; wen = 1'b1;
    tick;
    chk("fl_count", 32'(count0), 0);
    chk("fl_empty", 32'(empty0), 1);
    chk("fl_aempty", 32'(aempty0), 1);
    chk("fl_afull_clr", 32'(afull0), 0);
    chk("fl_rvld0", 32'(rvld0), 0);
    chk("fl_rvld1", 32'(rvld1), 0);
    chk("fl_ovf", 32'(overflow0), 0);
    chk("fl_udf", 32'(underflow0), 0);
    sclr = 1'b0; wen = 1'b0; ren = 1'b0;
    tick;
    chk("fl_post_rvld0", 32'(rvld0), 0);
    chk("fl_post_rvld1", 32'(rvld1), 0);
    wen = 1'b1; wdata = 8'hA5;
    tick;
    chk("fl_wr_count", 32'(count0), 1);
    wen = 1'b0; ren = 1'b1;
    tick;
    chk("fl_rd_vld0", 32'(rvld0), 1);
    chk("fl_rd_data0", 32'(rdata0), 32'hA5);
    ren = 1'b0;
    tick;
    chk("fl_rd_vld1", 32'(rvld1), 1);
    chk("fl_rd_data1", 32'(rdata1), 32'hA5);
    wen = 1'b1; wdata = 8'h61;
    tick;
    wdata = 8'h62;
    tick;
    wen = 1'b0; ren = 1'b1;
    tick;
    chk("mr_rvld0", 32'(rvld0), 1);
    chk("mr_rdata0", 32'(rdata0), 32'h61);
    ren = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_rvld0_drop", 32'(rvld0), 0);
    chk("mr_rvld1_drop", 32'(rvld1), 0);
    chk("mr_count", 32'(count0), 0);
    chk("mr_empty", 32'(empty0), 1);
    chk("mr_full", 32'(full0), 0);
    tick;
    chk("mr_rvld1_hold", 32'(rvld1), 0);
    rst_n = 1'b1;
    tick;
    chk("mr_empty_after", 32'(empty1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
